// File: rtl/avalon_bridge_arbiter.sv
// avalon_bridge_arbiter: shares one external-bus-to-Avalon bridge master
// between two requesters, one transaction at a time, with a watchdog.
module avalon_bridge_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 16,
    parameter int BE_W       = 2,
    parameter int TIMEOUT    = 255,
    parameter int PRIORITY_A = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [BE_W-1:0]   a_be,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [BE_W-1:0]   b_be,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] bridge_address,
    output logic [BE_W-1:0]   bridge_byte_enable,
    output logic              bridge_read,
    output logic              bridge_write,
    output logic [DATA_W-1:0] bridge_write_data,
    input  logic              bridge_acknowledge,
    input  logic [DATA_W-1:0] bridge_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic              last_b_q, last_b_d;
    logic              win_b_q, win_b_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              a_err_q, a_err_d;
    logic              b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic grant_b;
    logic expired;

    // B wins when alone, or on a conflict under round-robin after A's turn
    assign grant_b = b_req && (!a_req || (PRIORITY_A == 0 && !last_b_q));
    assign expired = (cnt_q == CNT_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (a_req || b_req) state_d = BUSY;
            BUSY:    if (bridge_acknowledge || expired) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // grant, completion and watchdog actions
    always_comb begin
        last_b_d  = last_b_q;
        win_b_d   = win_b_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wd_d      = wd_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    win_b_d  = grant_b;
                    last_b_d = grant_b;
                    cnt_d    = 8'd0;
                    rd_d     = grant_b ? !b_we : !a_we;
                    wr_d     = grant_b ? b_we : a_we;
                    addr_d   = grant_b ? b_addr : a_addr;
                    be_d     = grant_b ? b_be : a_be;
                    wd_d     = grant_b ? b_wdata : a_wdata;
                end
            end
            BUSY: begin
                if (bridge_acknowledge) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (win_b_q) begin
                        b_ack_d = 1'b1;
                        if (rd_q) b_rdata_d = bridge_read_data;
                    end else begin
                        a_ack_d = 1'b1;
                        if (rd_q) a_rdata_d = bridge_read_data;
                    end
                end else if (expired) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (win_b_q) begin
                        b_ack_d = 1'b1;
                        b_err_d = 1'b1;
                        if (rd_q) b_rdata_d = '0;
                    end else begin
                        a_ack_d = 1'b1;
                        a_err_d = 1'b1;
                        if (rd_q) a_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RECOVER: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
            default: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        endcase
    end

    // datapath and output registers; B is "last granted" out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b_q  <= 1'b1;
            win_b_q   <= 1'b0;
            cnt_q     <= 8'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            last_b_q  <= last_b_d;
            win_b_q   <= win_b_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wd_q      <= wd_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign bridge_read        = rd_q;
    assign bridge_write       = wr_q;
    assign bridge_address     = addr_q;
    assign bridge_byte_enable = be_q;
    assign bridge_write_data  = wd_q;
    assign a_ack              = a_ack_q;
    assign b_ack              = b_ack_q;
    assign a_err              = a_err_q;
    assign b_err              = b_err_q;
    assign a_rdata            = a_rdata_q;
    assign b_rdata            = b_rdata_q;
    assign busy               = (state_q != IDLE);

endmodule
